uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the 8N1 UART receiver. It captures each received byte and its framing-error flag on the receiver's 1-clk valid pulse, and stores them in a circular buffer of power-of-two depth. Consumers read the buffer through a registered rd_en/rd_valid handshake. The block also keeps a sticky overrun flag and a saturating framing-error counter for status registers.

---
 rtl/uart_rx_fifo.sv | 84 ++++++++
 tb/tb_uart_rx_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind an 8N1 UART receiver: circular store of {ferr,data},
// registered read port, sticky overrun flag and saturating framing-error counter.
module uart_rx_fifo #(
   parameter int ADDR_W    = 4,
   parameter bit DROP_FERR = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              framing_error,
   input  logic              rd_en,
   output logic [7:0]        dout,
   output logic              dout_ferr,
   output logic              rd_valid,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overrun,
   output logic [7:0]        ferr_cnt,
   input  logic              clr_status
);

   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [8:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wp, rp;
   logic              wr_req, rd_ok, wr_ok, ferr_hit;

   assign empty    = (count == '0);
   assign full     = (count == DEPTH_C);
   assign wr_req   = rx_valid & ~(DROP_FERR & framing_error);
   assign rd_ok    = rd_en & ~empty;
   // a read in the same cycle frees a slot, so a full buffer still accepts
   assign wr_ok    = wr_req & (~full | rd_ok);
   assign ferr_hit = rx_valid & framing_error;

   always_ff @(posedge clk) begin
      if (!rst && wr_ok)
         mem[wp] <= {framing_error, rx_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         dout      <= 8'h00;
         dout_ferr <= 1'b0;
         rd_valid  <= 1'b0;
         overrun   <= 1'b0;
         ferr_cnt  <= 8'h00;
      end else begin
         rd_valid <= rd_ok;
         if (wr_ok)
            wp <= wp + PTR_ONE;
         if (rd_ok) begin
            {dout_ferr, dout} <= mem[rp];
            rp                <= rp + PTR_ONE;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase

         // set beats clear when both land in the same cycle
         if (wr_req && !wr_ok)
            overrun <= 1'b1;
         else if (clr_status)
            overrun <= 1'b0;

         if (ferr_hit)
            ferr_cnt <= clr_status ? 8'h01 :
                        (ferr_cnt == 8'hFF) ? 8'hFF : ferr_cnt + 8'h01;
         else if (clr_status)
            ferr_cnt <= 8'h00;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: two instances (store / drop framing-error bytes) share stimulus
// and are compared every cycle against a queue-based model plus literal checkpoints.
module tb_uart_rx_fifo;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst, rx_valid, framing_error, rd_en, clr_status;
   logic [7:0]    rx_data;

   logic [7:0]    dout0, dout1, fcnt0, fcnt1;
   logic          dferr0, dferr1, rv0, rv1, emp0, emp1, full0, full1, ov0, ov1;
   logic [AW:0]   cnt0, cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.ADDR_W(AW), .DROP_FERR(1'b0)) dut0 (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .framing_error(framing_error), .rd_en(rd_en), .dout(dout0), .dout_ferr(dferr0),
      .rd_valid(rv0), .empty(emp0), .full(full0), .count(cnt0), .overrun(ov0),
      .ferr_cnt(fcnt0), .clr_status(clr_status));

   uart_rx_fifo #(.ADDR_W(AW), .DROP_FERR(1'b1)) dut1 (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .framing_error(framing_error), .rd_en(rd_en), .dout(dout1), .dout_ferr(dferr1),
      .rd_valid(rv1), .empty(emp1), .full(full1), .count(cnt1), .overrun(ov1),
      .ferr_cnt(fcnt1), .clr_status(clr_status));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [8:0] q0[$], q1[$];
   logic [7:0] m_dout [2];
   logic       m_ferr [2];
   logic       m_rv   [2];
   logic       m_ov   [2];
   int         m_fc   [2];
   bit         started = 0;

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int  sz;
         bit  wreq, rok, wok;
         logic [8:0] e;
         sz = (d == 0) ? q0.size() : q1.size();
         if (rst) begin
            if (d == 0) q0.delete(); else q1.delete();
            m_dout[d] = 8'h00; m_ferr[d] = 1'b0; m_rv[d] = 1'b0;
            m_ov[d] = 1'b0; m_fc[d] = 0;
         end else begin
            wreq = rx_valid && !(d == 1 && framing_error);
            rok  = rd_en && sz > 0;
            wok  = wreq && (sz < DEPTH || rok);
            m_rv[d] = rok;
            if (rok) begin
               e = (d == 0) ? q0.pop_front() : q1.pop_front();
               m_ferr[d] = e[8];
               m_dout[d] = e[7:0];
            end
            if (wok) begin
               if (d == 0) q0.push_back({framing_error, rx_data});
               else        q1.push_back({framing_error, rx_data});
            end
            if (wreq && !wok) m_ov[d] = 1'b1;
            else if (clr_status) m_ov[d] = 1'b0;
            if (rx_valid && framing_error)
               m_fc[d] = clr_status ? 1 : (m_fc[d] >= 255 ? 255 : m_fc[d] + 1);
            else if (clr_status)
               m_fc[d] = 0;
         end
      end
      if (rst) started = 1;
   end

   always @(negedge clk) begin
      if (started) begin
         chk("dout0",  dout0,  m_dout[0]);
         chk("dferr0", dferr0, m_ferr[0]);
         chk("rv0",    rv0,    m_rv[0]);
         chk("cnt0",   cnt0,   q0.size());
         chk("emp0",   emp0,   q0.size() == 0);
         chk("full0",  full0,  q0.size() == DEPTH);
         chk("ov0",    ov0,    m_ov[0]);
         chk("fcnt0",  fcnt0,  m_fc[0]);
         chk("dout1",  dout1,  m_dout[1]);
         chk("dferr1", dferr1, m_ferr[1]);
         chk("rv1",    rv1,    m_rv[1]);
         chk("cnt1",   cnt1,   q1.size());
         chk("emp1",   emp1,   q1.size() == 0);
         chk("full1",  full1,  q1.size() == DEPTH);
         chk("ov1",    ov1,    m_ov[1]);
         chk("fcnt1",  fcnt1,  m_fc[1]);
      end
   end

   // ---------------- stimulus ----------------
   // Applies one cycle of inputs; returns #1 after the edge that consumed them.
   task automatic cyc(input logic v, input logic [7:0] d, input logic f,
                      input logic r, input logic c);
      rx_valid = v; rx_data = d; framing_error = f; rd_en = r; clr_status = c;
      @(posedge clk); #1;
      rx_valid = 0; rx_data = 8'h00; framing_error = 0; rd_en = 0; clr_status = 0;
   endtask

   task automatic do_rst();
      rst = 1; @(posedge clk); #1; rst = 0;
   endtask

   initial begin
      rst = 1; rx_valid = 0; rx_data = 0; framing_error = 0; rd_en = 0; clr_status = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 0;
      chk("rst_count", cnt0, 0);
      chk("rst_empty", emp0, 1);
      chk("rst_dout",  dout0, 8'h00);

      // three bytes, then back-to-back reads
      cyc(1, 8'h41, 0, 0, 0); cyc(1, 8'h42, 0, 0, 0); cyc(1, 8'h43, 0, 0, 0);
      cyc(0, 0, 0, 1, 0); chk("b2b_rv1", rv0, 1); chk("b2b_d1", dout0, 8'h41);
      cyc(0, 0, 0, 1, 0); chk("b2b_rv2", rv0, 1); chk("b2b_d2", dout0, 8'h42);
      cyc(0, 0, 0, 1, 0); chk("b2b_rv3", rv0, 1); chk("b2b_d3", dout0, 8'h43);
      chk("b2b_empty", emp0, 1); chk("b2b_count", cnt0, 0);
      cyc(0, 0, 0, 1, 0); chk("rd_empty_rv", rv0, 0); chk("rd_empty_hold", dout0, 8'h43);

      // fill, overflow, drain
      for (int i = 0; i < 16; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 0);
      chk("fill_full", full0, 1); chk("fill_count", cnt0, 16);
      cyc(1, 8'hEE, 0, 0, 0);
      chk("ovr_flag", ov0, 1); chk("ovr_count", cnt0, 16);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 0, 0, 1, 0);
         chk("drain_data", dout0, 8'h10 + 8'(i));
      end
      chk("drain_empty", emp0, 1);
      cyc(0, 0, 0, 0, 1); chk("ovr_clr", ov0, 0);

      // full with simultaneous write and read
      for (int i = 0; i < 16; i++) cyc(1, 8'h20 + 8'(i), 0, 0, 0);
      cyc(1, 8'h99, 0, 1, 0);
      chk("fwr_count", cnt0, 16); chk("fwr_ovr", ov0, 0); chk("fwr_d", dout0, 8'h20);
      for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1, 0);
      chk("fwr_d15", dout0, 8'h2F);
      cyc(0, 0, 0, 1, 0); chk("fwr_last", dout0, 8'h99); chk("fwr_empty", emp0, 1);

      // empty with simultaneous write and read: no bypass
      cyc(1, 8'h55, 0, 1, 0);
      chk("ewr_rv", rv0, 0); chk("ewr_count", cnt0, 1);
      cyc(0, 0, 0, 1, 0); chk("ewr_rv2", rv0, 1); chk("ewr_d", dout0, 8'h55);

      // framing error tagging / dropping
      cyc(1, 8'h7F, 1, 0, 0);
      chk("fe_cnt_keep", cnt0, 1); chk("fe_cnt_drop", cnt1, 0);
      chk("fe_fc0", fcnt0, 1); chk("fe_fc1", fcnt1, 1);
      cyc(0, 0, 0, 1, 0);
      chk("fe_d", dout0, 8'h7F); chk("fe_tag", dferr0, 1); chk("fe_drop_rv", rv1, 0);

      // saturation, coincident clear, plain clear
      for (int i = 0; i < 300; i++) cyc(1, 8'(i), 1, 0, 0);
      chk("fe_sat0", fcnt0, 8'hFF); chk("fe_sat1", fcnt1, 8'hFF);
      cyc(1, 8'h01, 1, 0, 1); chk("fe_clr_inc", fcnt0, 1);
      cyc(0, 0, 0, 0, 1); chk("fe_clr", fcnt0, 0);

      // mid-stream reset
      for (int i = 0; i < 5; i++) cyc(1, 8'hA0 + 8'(i), 0, 0, 0);
      chk("pre_rst_ovr", ov0, 1);
      do_rst();
      chk("mrst_count", cnt0, 0); chk("mrst_empty", emp0, 1);
      chk("mrst_dout", dout0, 8'h00); chk("mrst_ovr", ov0, 0);

      // pointer wrap over 40 sequential bytes
      for (int i = 0; i < 40; i++) begin
         cyc(1, 8'hC0 + 8'(i), 0, 0, 0);
         cyc(0, 0, 0, 1, 0);
         chk("wrap_d", dout0, 8'hC0 + 8'(i));
      end

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         int rd_pct;
         rd_pct = (n < 2000) ? 30 : 70;
         rst = ($urandom_range(299) == 0);
         cyc($urandom_range(1), 8'($urandom), ($urandom_range(7) == 0),
             ($urandom_range(99) < rd_pct), ($urandom_range(49) == 0));
         rst = 0;
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
